// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite register slice.
// Holds the AXI-Lite field widths, the response codes, and the state
// type used by each skid buffer.
package axil_pkg;

  localparam int unsigned AXIL_PROT_W = 3;
  localparam int unsigned AXIL_RESP_W = 2;

  localparam logic [AXIL_RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXIL_RESP_W-1:0] RESP_SLVERR = 2'b10;

  // Occupancy of one skid buffer: no beat, main register only,
  // or main plus skid register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/axil_skid_buf.sv
// Generic fully-registered valid/ready skid buffer.
// Both o_in_ready and o_out_valid come straight from flops, so there is no
// combinational path from the input side to the output side or back.
// The buffer accepts one beat per cycle when the output side is ready.
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   i_in_valid/o_in_ready  upstream handshake, i_in_data upstream payload
//   o_out_valid/i_out_ready downstream handshake, o_out_data downstream payload
module axil_skid_buf
  import axil_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data
);

  skid_state_e      r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic w_in_fire;
  logic w_out_fire;

  assign w_in_fire  = i_in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & i_out_ready;

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_main;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          // Ready is held low for the first cycle after reset and rises here.
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            r_main      <= i_in_data;
            r_out_valid <= 1'b1;
            r_state     <= ONE;
          end
        end
        ONE: begin
          if (w_in_fire && !w_out_fire) begin
            // Downstream stalled: park the new beat and stop accepting.
            r_skid     <= i_in_data;
            r_in_ready <= 1'b0;
            r_state    <= TWO;
          end else if (w_out_fire && !w_in_fire) begin
            r_out_valid <= 1'b0;
            r_state     <= EMPTY;
          end else if (w_in_fire && w_out_fire) begin
            r_main <= i_in_data;
          end
        end
        TWO: begin
          if (w_out_fire) begin
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= ONE;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/axil_reg_slice.sv
// AXI4-Lite register slice between the PCIe bridge AXI-Lite master and the
// register-file slave. Each of the five channels passes through its own
// skid buffer, so every valid, ready and payload path is registered.
// AW, W and AR flow S->M; B and R flow M->S. Payloads are never altered.
// Ports:
//   clk, reset   AXI clock, synchronous active-high reset
//   S_AXI_*      slave-side port facing the bridge master
//   M_AXI_*      master-side port facing the register file
module axil_reg_slice
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 40,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [AXIL_PROT_W-1:0]  S_AXI_AWPROT,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [AXIL_RESP_W-1:0]  S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [AXIL_PROT_W-1:0]  S_AXI_ARPROT,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [AXIL_RESP_W-1:0]  S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [AXIL_PROT_W-1:0]  M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [AXIL_RESP_W-1:0]  M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [AXIL_PROT_W-1:0]  M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [AXIL_RESP_W-1:0]  M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned AX_W   = ADDR_WIDTH + AXIL_PROT_W;
  localparam int unsigned WD_W   = DATA_WIDTH + STRB_W;
  localparam int unsigned RD_W   = DATA_WIDTH + AXIL_RESP_W;

  axil_skid_buf #(.WIDTH(AX_W)) u_aw (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (S_AXI_AWVALID),
    .o_in_ready  (S_AXI_AWREADY),
    .i_in_data   ({S_AXI_AWPROT, S_AXI_AWADDR}),
    .o_out_valid (M_AXI_AWVALID),
    .i_out_ready (M_AXI_AWREADY),
    .o_out_data  ({M_AXI_AWPROT, M_AXI_AWADDR})
  );

  axil_skid_buf #(.WIDTH(WD_W)) u_w (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (S_AXI_WVALID),
    .o_in_ready  (S_AXI_WREADY),
    .i_in_data   ({S_AXI_WSTRB, S_AXI_WDATA}),
    .o_out_valid (M_AXI_WVALID),
    .i_out_ready (M_AXI_WREADY),
    .o_out_data  ({M_AXI_WSTRB, M_AXI_WDATA})
  );

  axil_skid_buf #(.WIDTH(AXIL_RESP_W)) u_b (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (M_AXI_BVALID),
    .o_in_ready  (M_AXI_BREADY),
    .i_in_data   (M_AXI_BRESP),
    .o_out_valid (S_AXI_BVALID),
    .i_out_ready (S_AXI_BREADY),
    .o_out_data  (S_AXI_BRESP)
  );

  axil_skid_buf #(.WIDTH(AX_W)) u_ar (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (S_AXI_ARVALID),
    .o_in_ready  (S_AXI_ARREADY),
    .i_in_data   ({S_AXI_ARPROT, S_AXI_ARADDR}),
    .o_out_valid (M_AXI_ARVALID),
    .i_out_ready (M_AXI_ARREADY),
    .o_out_data  ({M_AXI_ARPROT, M_AXI_ARADDR})
  );

  axil_skid_buf #(.WIDTH(RD_W)) u_r (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (M_AXI_RVALID),
    .o_in_ready  (M_AXI_RREADY),
    .i_in_data   ({M_AXI_RRESP, M_AXI_RDATA}),
    .o_out_valid (S_AXI_RVALID),
    .i_out_ready (S_AXI_RREADY),
    .o_out_data  ({S_AXI_RRESP, S_AXI_RDATA})
  );

endmodule

// File: tb/tb_axil_reg_slice.sv
// Self-checking bench for axil_reg_slice. Channels are indexed
// 0=AW, 1=W, 2=B, 3=AR, 4=R; "in" is the side that produces beats.
// A negedge scoreboard models each channel as a FIFO of at most two beats.
module tb_axil_reg_slice;
  import axil_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        iv[5];
  logic [63:0] ip[5];
  logic        ordy[5];
  logic        in_r[5];
  logic        out_v[5];
  logic [63:0] op[5];

  logic s_awready, s_wready, s_arready, m_bready, m_rready;
  logic [39:0] m_awaddr, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic        m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid;
  logic [31:0] m_wdata, s_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  s_bresp, s_rresp;

  axil_reg_slice #(.ADDR_WIDTH(40), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .S_AXI_AWADDR(ip[0][39:0]), .S_AXI_AWPROT(ip[0][42:40]), .S_AXI_AWVALID(iv[0]), .S_AXI_AWREADY(s_awready),
    .S_AXI_WDATA(ip[1][31:0]), .S_AXI_WSTRB(ip[1][35:32]), .S_AXI_WVALID(iv[1]), .S_AXI_WREADY(s_wready),
    .S_AXI_BRESP(s_bresp), .S_AXI_BVALID(s_bvalid), .S_AXI_BREADY(ordy[2]),
    .S_AXI_ARADDR(ip[3][39:0]), .S_AXI_ARPROT(ip[3][42:40]), .S_AXI_ARVALID(iv[3]), .S_AXI_ARREADY(s_arready),
    .S_AXI_RDATA(s_rdata), .S_AXI_RRESP(s_rresp), .S_AXI_RVALID(s_rvalid), .S_AXI_RREADY(ordy[4]),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWPROT(m_awprot), .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(ordy[0]),
    .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(ordy[1]),
    .M_AXI_BRESP(ip[2][1:0]), .M_AXI_BVALID(iv[2]), .M_AXI_BREADY(m_bready),
    .M_AXI_ARADDR(m_araddr), .M_AXI_ARPROT(m_arprot), .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(ordy[3]),
    .M_AXI_RDATA(ip[4][31:0]), .M_AXI_RRESP(ip[4][33:32]), .M_AXI_RVALID(iv[4]), .M_AXI_RREADY(m_rready)
  );

  always_comb begin
    in_r[0] = s_awready; out_v[0] = m_awvalid; op[0] = {21'b0, m_awprot, m_awaddr};
    in_r[1] = s_wready;  out_v[1] = m_wvalid;  op[1] = {28'b0, m_wstrb, m_wdata};
    in_r[2] = m_bready;  out_v[2] = s_bvalid;  op[2] = {62'b0, s_bresp};
    in_r[3] = s_arready; out_v[3] = m_arvalid; op[3] = {21'b0, m_arprot, m_araddr};
    in_r[4] = m_rready;  out_v[4] = s_rvalid;  op[4] = {30'b0, s_rresp, s_rdata};
  end

  string       chn[5] = '{"AW", "W", "B", "AR", "R"};
  logic [63:0] mask[5] = '{64'h7FF_FFFF_FFFF, 64'hF_FFFF_FFFF, 64'h3, 64'h7FF_FFFF_FFFF, 64'h3_FFFF_FFFF};

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Scoreboard: each channel holds up to two in-flight beats in order.
  logic [63:0] q[5][$];
  bit          fired[5];
  bit          model_on = 1'b0;
  bit          rst_seen = 1'b0;

  always @(negedge clk) begin
    bit ev, er, inf, outf;
    for (int ch = 0; ch < 5; ch++) begin
      ev = (q[ch].size() > 0);
      er = !rst_seen && (q[ch].size() < 2);
      if (model_on) begin
        chk({chn[ch], "_out_valid"}, 64'(out_v[ch]), 64'(ev));
        chk({chn[ch], "_in_ready"},  64'(in_r[ch]),  64'(er));
        if (ev) chk({chn[ch], "_payload"}, op[ch], q[ch][0]);
      end
      fired[ch] = 1'b0;
      if (reset) begin
        q[ch].delete();
      end else if (model_on) begin
        inf  = iv[ch] && er;
        outf = ev && ordy[ch];
        if (outf) void'(q[ch].pop_front());
        if (inf) q[ch].push_back(ip[ch] & mask[ch]);
        fired[ch] = inf;
      end
    end
    if (reset) begin
      model_on = 1'b1;
      rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int ch = 0; ch < 5; ch++) begin
      iv[ch] = 1'b0;
      ordy[ch] = 1'b1;
    end
  endtask

  function automatic logic [31:0] regval(input int unsigned a);
    return 32'hC0DE_0000 | a[31:0];
  endfunction

  typedef struct {
    int unsigned ch;
    logic [63:0] pay;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{0, 64'h000_0000_0008, 64'h000_0000_0008};
    tbl[1] = '{1, 64'hF_A5A5_0001,   64'hF_A5A5_0001};
    tbl[2] = '{2, 64'(RESP_OKAY),    64'h0};
    tbl[3] = '{2, 64'(RESP_SLVERR),  64'h2};
    tbl[4] = '{3, 64'h000_0000_0000, 64'h000_0000_0000};
    tbl[5] = '{4, 64'h0_DEAD_BEEF,   64'h0_DEAD_BEEF};
    tbl[6] = '{0, 64'h7FF_FFFF_FFFF, 64'h7FF_FFFF_FFFF};
    tbl[7] = '{4, 64'h2_0000_0000,   64'h2_0000_0000};

    for (int ch = 0; ch < 5; ch++) ip[ch] = '0;
    idle();
    reset = 1'b1;
    repeat (3) step();
    @(negedge clk);
    for (int ch = 0; ch < 5; ch++) begin
      chk({"rst_", chn[ch], "_valid"}, 64'(out_v[ch]), 64'd0);
      chk({"rst_", chn[ch], "_ready"}, 64'(in_r[ch]), 64'd0);
      chk({"rst_", chn[ch], "_payload"}, op[ch], 64'd0);
    end
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    for (int ch = 0; ch < 5; ch++) chk({"post_rst_", chn[ch], "_ready"}, 64'(in_r[ch]), 64'd1);

    // Single-beat pass-through vectors: valid one cycle after accept, then empty.
    for (int i = 0; i < 8; i++) begin
      step();
      iv[tbl[i].ch] = 1'b1;
      ip[tbl[i].ch] = tbl[i].pay;
      step();
      iv[tbl[i].ch] = 1'b0;
      @(negedge clk);
      chk({"vec_", chn[tbl[i].ch], "_valid"}, 64'(out_v[tbl[i].ch]), 64'd1);
      chk({"vec_", chn[tbl[i].ch], "_data"}, op[tbl[i].ch], tbl[i].exp);
      step();
      @(negedge clk);
      chk({"vec_", chn[tbl[i].ch], "_drain"}, 64'(out_v[tbl[i].ch]), 64'd0);
    end

    // Back-pressure on AR: three back-to-back requests against a stalled slave.
    step();
    ordy[3] = 1'b0;
    iv[3] = 1'b1;
    ip[3] = 64'h00;
    step();
    ip[3] = 64'h04;
    step();
    ip[3] = 64'h08;
    @(negedge clk);
    chk("bp_ready_drop", 64'(s_arready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("bp_stall_addr", 64'(m_araddr), 64'h00);
      chk("bp_stall_valid", 64'(m_arvalid), 64'd1);
    end
    step();
    ordy[3] = 1'b1;
    step();
    @(negedge clk);
    chk("bp_addr1", 64'(m_araddr), 64'h04);
    chk("bp_ready_back", 64'(s_arready), 64'd1);
    step();
    iv[3] = 1'b0;
    @(negedge clk);
    chk("bp_addr2", 64'(m_araddr), 64'h08);
    step();
    @(negedge clk);
    chk("bp_done", 64'(m_arvalid), 64'd0);

    // Full throughput: 16 read-data beats on consecutive cycles.
    step();
    ordy[4] = 1'b1;
    iv[4] = 1'b1;
    ip[4] = {32'b0, regval(0)};
    for (int unsigned k = 0; k < 16; k++) begin
      step();
      if (k == 15) iv[4] = 1'b0;
      else ip[4] = {32'b0, regval(4 * (k + 1))};
      @(negedge clk);
      chk("tput_valid", 64'(s_rvalid), 64'd1);
      chk("tput_data", 64'(s_rdata), 64'(regval(4 * k)));
    end
    step();
    @(negedge clk);
    chk("tput_end", 64'(s_rvalid), 64'd0);

    // W leads AW by four cycles; each is forwarded on its own, one B returns.
    step();
    iv[1] = 1'b1;
    ip[1] = 64'hF_1234_5678;
    step();
    iv[1] = 1'b0;
    @(negedge clk);
    chk("dec_w_valid", 64'(m_wvalid), 64'd1);
    chk("dec_w_data", 64'(m_wdata), 64'h1234_5678);
    chk("dec_aw_idle", 64'(m_awvalid), 64'd0);
    repeat (3) step();
    iv[0] = 1'b1;
    ip[0] = 64'h10;
    step();
    iv[0] = 1'b0;
    @(negedge clk);
    chk("dec_aw_valid", 64'(m_awvalid), 64'd1);
    chk("dec_aw_addr", 64'(m_awaddr), 64'h10);
    chk("dec_w_gone", 64'(m_wvalid), 64'd0);
    step();
    iv[2] = 1'b1;
    ip[2] = 64'(RESP_OKAY);
    step();
    iv[2] = 1'b0;
    @(negedge clk);
    chk("dec_b_valid", 64'(s_bvalid), 64'd1);
    chk("dec_b_resp", 64'(s_bresp), 64'd0);
    step();
    @(negedge clk);
    chk("dec_b_single", 64'(s_bvalid), 64'd0);

    // Reset while AR holds two stalled beats.
    step();
    ordy[3] = 1'b0;
    iv[3] = 1'b1;
    ip[3] = 64'h20;
    step();
    ip[3] = 64'h24;
    step();
    iv[3] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_full", 64'(s_arready), 64'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    for (int ch = 0; ch < 5; ch++) begin
      chk({"mrst_", chn[ch], "_valid"}, 64'(out_v[ch]), 64'd0);
      chk({"mrst_", chn[ch], "_ready"}, 64'(in_r[ch]), 64'd0);
    end
    chk("mrst_ar_payload", op[3], 64'd0);
    step();
    ordy[3] = 1'b1;
    @(negedge clk);
    for (int ch = 0; ch < 5; ch++) chk({"mrst2_", chn[ch], "_ready"}, 64'(in_r[ch]), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("mrst_no_stale", 64'(m_arvalid), 64'd0);
    end

    // Randomized traffic on all channels, scored by the negedge model.
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      step();
      for (int ch = 0; ch < 5; ch++) begin
        if (!iv[ch] || fired[ch]) begin
          iv[ch] = ($urandom_range(0, 3) != 0);
          ip[ch] = {$urandom(), $urandom()} & mask[ch];
        end
        if (cyc < 1000) ordy[ch] = ($urandom_range(0, 3) != 0);
        else if (cyc < 2000) ordy[ch] = ($urandom_range(0, 3) == 0);
        else ordy[ch] = ($urandom_range(0, 1) != 0);
      end
      reset = (cyc == 1500);
    end
    step();
    reset = 1'b0;
    idle();
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
